// File: rtl/mult_seq_if.sv
// mult_seq_if: operand and handshake bundle between a requester and mult_seq.
// The requester drives start/sign_mode/x/y; the multiplier returns busy/done/out.
interface mult_seq_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic                 sign_mode;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   out;

    modport master (
        output start,
        output sign_mode,
        output x,
        output y,
        input  busy,
        input  done,
        input  out
    );

    modport slave (
        input  start,
        input  sign_mode,
        input  x,
        input  y,
        output busy,
        output done,
        output out
    );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: sequential shift-add multiplier reusing one WIDTH+1 bit adder over WIDTH cycles.
// Signed operands are multiplied as magnitudes; the sign is restored when the result is stored.
module mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    mult_seq_if.slave bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [PW-1:0]    acc_r;
    logic [PW-1:0]    acc_s;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mcand_s;
    logic [WIDTH-1:0] mlr_r;
    logic [WIDTH-1:0] mlr_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             neg_r;
    logic             neg_s;
    logic [PW-1:0]    out_r;
    logic [PW-1:0]    out_s;
    logic             done_r;
    logic             done_s;
    logic             busy_r;
    logic             busy_s;
    logic [WIDTH:0]   sum_s;
    logic             accept_s;
    logic [WIDTH-1:0] cap_mcand_s;
    logic [WIDTH-1:0] cap_mlr_s;
    logic             cap_neg_s;

    // Unsigned magnitude of an operand; -2^(WIDTH-1) maps onto 2^(WIDTH-1), which still fits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] m;
        if (sgn && v[WIDTH-1]) begin
            m = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction

    function automatic logic [PW-1:0] negate(input logic [PW-1:0] v);
        return ~v + {{(PW-1){1'b0}}, 1'b1};
    endfunction

    // Operand capture values and the single shared adder on the upper accumulator half.
    always_comb begin
        accept_s    = bus.start && ((state_r == IDLE) || (state_r == FINISH));
        cap_mcand_s = magnitude(bus.x, bus.sign_mode);
        cap_mlr_s   = magnitude(bus.y, bus.sign_mode);
        cap_neg_s   = bus.sign_mode & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
        if (mlr_r[0]) begin
            sum_s = {1'b0, acc_r[PW-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, acc_r[PW-1:WIDTH]};
        end
    end

    // Next-state and datapath update; FINISH may immediately accept the next operation.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        mcand_s = mcand_r;
        mlr_s   = mlr_r;
        cnt_s   = cnt_r;
        neg_s   = neg_r;
        out_s   = out_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                    mcand_s = cap_mcand_s;
                    mlr_s   = cap_mlr_s;
                    neg_s   = cap_neg_s;
                    acc_s   = {PW{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                acc_s = {sum_s, acc_r[WIDTH-1:1]};
                mlr_s = {1'b0, mlr_r[WIDTH-1:1]};
                cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == LAST_ITER) begin
                    state_s = FINISH;
                end else begin
                    state_s = RUN;
                end
            end
            FINISH: begin
                done_s = 1'b1;
                if (neg_r) begin
                    out_s = negate(acc_r);
                end else begin
                    out_s = acc_r;
                end
                if (accept_s) begin
                    state_s = RUN;
                    mcand_s = cap_mcand_s;
                    mlr_s   = cap_mlr_s;
                    neg_s   = cap_neg_s;
                    acc_s   = {PW{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous reset taking priority over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= {PW{1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            mlr_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            neg_r   <= 1'b0;
            out_r   <= {PW{1'b0}};
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            mcand_r <= mcand_s;
            mlr_r   <= mlr_s;
            cnt_r   <= cnt_s;
            neg_r   <= neg_s;
            out_r   <= out_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.out  = out_r;
endmodule
